// File: rtl/draw_projectile_multi_pkg.sv
// Shared VGA geometry plus projectile coordinate/colour types for the multi-projectile overlay.
// Screen coordinates are 13-bit signed so mirrored positions can fall left of / above the screen.
package draw_projectile_multi_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef logic [11:0]        proj_pos_t;
    typedef logic signed [12:0] scr_coord_t;
    typedef logic [11:0]        rgb_t;

    localparam rgb_t DEFAULT_PROJ_COLOR = 12'hF00;

    function automatic scr_coord_t to_screen(input proj_pos_t pos, input int extent, input bit mirror);
        scr_coord_t p;
        p = scr_coord_t'({1'b0, pos});
        return mirror ? scr_coord_t'(extent) - p : p;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle; vga_in is the consumer view, vga_out the producer view.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_projectile_multi_proj_slot.sv
// One projectile slot: per-frame shadow position/enable, hit-flash counter, registered pixel hit test.
// Latency 1 cycle from hcount/vcount to draw_o/color_o; no backpressure.
module draw_projectile_multi_proj_slot
    import draw_projectile_multi_pkg::*;
#(
    parameter int   RECT_SIZE    = 30,
    parameter bit   MIRROR       = 1'b1,
    parameter rgb_t PROJ_COLOR   = DEFAULT_PROJ_COLOR,
    parameter rgb_t FLASH_COLOR  = 12'hFFF,
    parameter int   FLASH_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start_i,
    input  proj_pos_t   x_pos_i,
    input  proj_pos_t   y_pos_i,
    input  logic        active_i,
    input  logic        hit_i,
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    output logic        draw_o,
    output rgb_t        color_o
);

    localparam logic signed [13:0] RECT_S     = 14'(RECT_SIZE);
    localparam logic [7:0]         FLASH_LOAD = 8'(FLASH_FRAMES);

    proj_pos_t  x_q, y_q;
    logic       act_q;
    logic [7:0] flash_q;
    logic       draw_q;
    rgb_t       color_q;

    scr_coord_t left, top;
    logic signed [13:0] left_s, top_s, hc_s, vc_s;
    logic in_x, in_y;

    // One extra bit of headroom keeps left+RECT_SIZE from wrapping for large unmirrored positions.
    assign left   = to_screen(x_q, HOR_PIXELS, MIRROR);
    assign top    = to_screen(y_q, VER_PIXELS, MIRROR);
    assign left_s = {left[12], left};
    assign top_s  = {top[12], top};
    assign hc_s   = {3'b000, hcount_i};
    assign vc_s   = {3'b000, vcount_i};
    assign in_x   = (hc_s >= left_s) && (hc_s < left_s + RECT_S);
    assign in_y   = (vc_s >= top_s)  && (vc_s < top_s + RECT_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            act_q   <= 1'b0;
            flash_q <= '0;
            draw_q  <= 1'b0;
            color_q <= '0;
        end else begin
            if (frame_start_i) begin
                x_q   <= x_pos_i;
                y_q   <= y_pos_i;
                act_q <= active_i;
            end
            if (hit_i) begin
                flash_q <= FLASH_LOAD;
            end else if (frame_start_i && flash_q != 8'd0) begin
                flash_q <= flash_q - 8'd1;
            end
            draw_q  <= act_q & in_x & in_y;
            color_q <= (flash_q != 8'd0) ? FLASH_COLOR : PROJ_COLOR;
        end
    end

    assign draw_o  = draw_q;
    assign color_o = color_q;

endmodule

// File: rtl/draw_projectile_multi.sv
// Overlays N_PROJ square projectiles on the VGA stream; positions latched at each vblank rise.
// Fixed 2-cycle latency on all VGA fields; no backpressure.
module draw_projectile_multi
    import draw_projectile_multi_pkg::*;
#(
    parameter int   N_PROJ       = 4,
    parameter int   RECT_SIZE    = 30,
    parameter bit   MIRROR       = 1'b1,
    parameter rgb_t PROJ_COLOR   = DEFAULT_PROJ_COLOR,
    parameter rgb_t FLASH_COLOR  = 12'hFFF,
    parameter int   FLASH_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  proj_pos_t [N_PROJ-1:0] x_pos,
    input  proj_pos_t [N_PROJ-1:0] y_pos,
    input  logic [N_PROJ-1:0]      active,
    input  logic [N_PROJ-1:0]      hit,
    vga_if.vga_in                  vga_in,
    vga_if.vga_out                 vga_out
);

    logic        vblnk_prev_q;
    logic        frame_start;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    rgb_t        rgb_q, rgb_d;

    logic [N_PROJ-1:0] draw;
    rgb_t              color [N_PROJ];

    assign frame_start = vga_in.vblnk & ~vblnk_prev_q;

    for (genvar i = 0; i < N_PROJ; i++) begin : g_slot
        draw_projectile_multi_proj_slot #(
            .RECT_SIZE    (RECT_SIZE),
            .MIRROR       (MIRROR),
            .PROJ_COLOR   (PROJ_COLOR),
            .FLASH_COLOR  (FLASH_COLOR),
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_proj_slot (
            .clk           (clk),
            .rst           (rst),
            .frame_start_i (frame_start),
            .x_pos_i       (x_pos[i]),
            .y_pos_i       (y_pos[i]),
            .active_i      (active[i]),
            .hit_i         (hit[i]),
            .hcount_i      (vga_in.hcount),
            .vcount_i      (vga_in.vcount),
            .draw_o        (draw[i]),
            .color_o       (color[i])
        );
    end

    // Walk from highest index down so the lowest-index hit is the final assignment.
    always_comb begin
        rgb_d = rgb_q;
        if (!(hblnk_q || vblnk_q)) begin
            for (int i = N_PROJ - 1; i >= 0; i--) begin
                if (draw[i]) begin
                    rgb_d = color[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q   <= 1'b0;
            hcount_q       <= '0;
            vcount_q       <= '0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            hblnk_q        <= 1'b0;
            vblnk_q        <= 1'b0;
            rgb_q          <= '0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vblnk_prev_q   <= vga_in.vblnk;
            hcount_q       <= vga_in.hcount;
            vcount_q       <= vga_in.vcount;
            hsync_q        <= vga_in.hsync;
            vsync_q        <= vga_in.vsync;
            hblnk_q        <= vga_in.hblnk;
            vblnk_q        <= vga_in.vblnk;
            rgb_q          <= vga_in.rgb;
            vga_out.hcount <= hcount_q;
            vga_out.vcount <= vcount_q;
            vga_out.hsync  <= hsync_q;
            vga_out.vsync  <= vsync_q;
            vga_out.hblnk  <= hblnk_q;
            vga_out.vblnk  <= vblnk_q;
            vga_out.rgb    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_draw_projectile_multi.sv
// Bench for draw_projectile_multi: a mirrored (dut0) and a direct (dut1) instance share one VGA stream.
// A frame-level model predicts every output cycle; directed pixel checks pin the model.
module tb_draw_projectile_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0][11:0] x0, y0, x1, y1;
    logic [3:0]       act, hit;

    vga_if vin ();
    vga_if vo0 ();
    vga_if vo1 ();

    draw_projectile_multi #(.MIRROR(1'b1)) dut0 (
        .clk(clk), .rst(rst), .x_pos(x0), .y_pos(y0), .active(act), .hit(hit),
        .vga_in(vin), .vga_out(vo0)
    );
    draw_projectile_multi #(.MIRROR(1'b0)) dut1 (
        .clk(clk), .rst(rst), .x_pos(x1), .y_pos(y1), .active(act), .hit(hit),
        .vga_in(vin), .vga_out(vo1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [11:0] pat(input int hc, input int vc);
        return {1'b0, 5'(hc), 6'(vc)};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [10:0] hc, vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb0, rgb1;
    } exp_t;

    int   sh_x [2][4];
    int   sh_y [2][4];
    bit   sh_a [2][4];
    int   flash [2][4];
    bit   vprev = 1'b0;
    bit   rst_prev = 1'b1;
    exp_t e_prev = '0;
    exp_t exp_out = '0;
    int   cyc = 0;

    function automatic logic [11:0] model_pix(input int inst);
        int hc = int'(vin.hcount);
        int vc = int'(vin.vcount);
        int l, t;
        if (vin.hblnk || vin.vblnk) return vin.rgb;
        for (int i = 0; i < 4; i++) begin
            if (sh_a[inst][i]) begin
                l = (inst == 0) ? 800 - sh_x[inst][i] : sh_x[inst][i];
                t = (inst == 0) ? 600 - sh_y[inst][i] : sh_y[inst][i];
                if (hc >= l && hc < l + 30 && vc >= t && vc < t + 30)
                    return (flash[inst][i] != 0) ? 12'hFFF : 12'hF00;
            end
        end
        return vin.rgb;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   fs;
        e.hc = vin.hcount; e.vc = vin.vcount;
        e.hs = vin.hsync;  e.vs = vin.vsync;
        e.hb = vin.hblnk;  e.vb = vin.vblnk;
        e.rgb0 = model_pix(0);
        e.rgb1 = model_pix(1);
        exp_out = (rst || rst_prev) ? '0 : e_prev;
        e_prev = e;
        rst_prev = rst;
        if (rst) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4; i++) begin
                    sh_x[k][i] = 0; sh_y[k][i] = 0; sh_a[k][i] = 1'b0; flash[k][i] = 0;
                end
            vprev = 1'b0;
        end else begin
            fs = vin.vblnk && !vprev;
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 4; i++) begin
                    if (fs) begin
                        sh_x[k][i] = (k == 0) ? int'(x0[i]) : int'(x1[i]);
                        sh_y[k][i] = (k == 0) ? int'(y0[i]) : int'(y1[i]);
                        sh_a[k][i] = act[i];
                    end
                    if (hit[i]) flash[k][i] = 8;
                    else if (fs && flash[k][i] > 0) flash[k][i]--;
                end
            vprev = vin.vblnk;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    logic [11:0] seen0 [int];
    logic [11:0] seen1 [int];

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("out0_timing", {6'd0, vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk},
                  {6'd0, exp_out.hc, exp_out.vc, exp_out.hs, exp_out.vs, exp_out.hb, exp_out.vb});
            check("out0_rgb", {20'd0, vo0.rgb}, {20'd0, exp_out.rgb0});
            check("out1_timing", {6'd0, vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk},
                  {6'd0, exp_out.hc, exp_out.vc, exp_out.hs, exp_out.vs, exp_out.hb, exp_out.vb});
            check("out1_rgb", {20'd0, vo1.rgb}, {20'd0, exp_out.rgb1});
            if (vo0.hblnk === 1'b0 && vo0.vblnk === 1'b0)
                seen0[int'(vo0.vcount) * 2048 + int'(vo0.hcount)] = vo0.rgb;
            if (vo1.hblnk === 1'b0 && vo1.vblnk === 1'b0)
                seen1[int'(vo1.vcount) * 2048 + int'(vo1.hcount)] = vo1.rgb;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_px(input int hc, input int vc, input bit hb, input bit vb);
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hb && (hc % 2 == 0);
        vin.vsync  = vb && (hc < 2);
        vin.rgb    = pat(hc, vc);
        @(posedge clk);
        #1;
        hit = '0;
    endtask

    task automatic vblank();
        seen0.delete();
        seen1.delete();
        for (int h = 0; h < 4; h++) drive_px(h, 600, 1'b1, 1'b1);
    endtask

    task automatic scan_row(input int vc, input int lo, input int hi);
        for (int h = lo; h <= hi; h++) drive_px(h, vc, 1'b0, 1'b0);
        drive_px(800, vc, 1'b1, 1'b0);
        drive_px(801, vc, 1'b1, 1'b0);
    endtask

    task automatic chk_px(input string nm, input int inst, input int hc, input int vc, input logic [11:0] want);
        int key = vc * 2048 + hc;
        logic [31:0] got = 32'hDEAD_BEEF;
        if (inst == 0 && seen0.exists(key)) got = {20'd0, seen0[key]};
        if (inst == 1 && seen1.exists(key)) got = {20'd0, seen1[key]};
        check(nm, got, {20'd0, want});
    endtask

    initial begin
        rst = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; act = '0; hit = '0;
        for (int i = 0; i < 3; i++) drive_px(800, 0, 1'b1, 1'b0);
        check("reset_timing", {6'd0, vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk}, 32'd0);
        check("reset_rgb", {20'd0, vo0.rgb}, 32'd0);
        rst = 1'b0;

        // Basic draw; nothing visible until the first vblank rise latches the shadows
        act = 4'b0001; x0[0] = 12'd400; y0[0] = 12'd300; x1[0] = 12'd400; y1[0] = 12'd300;
        scan_row(300, 399, 401);
        chk_px("t1_prelatch", 0, 400, 300, pat(400, 300));
        vblank();
        scan_row(300, 398, 431);
        chk_px("t1_left_out", 0, 399, 300, pat(399, 300));
        chk_px("t1_left_in", 0, 400, 300, 12'hF00);
        chk_px("t1_right_in", 0, 429, 300, 12'hF00);
        chk_px("t1_right_out", 0, 430, 300, pat(430, 300));
        chk_px("t1_direct", 1, 400, 300, 12'hF00);
        scan_row(329, 429, 430);
        chk_px("t1_bottom_in", 0, 429, 329, 12'hF00);
        chk_px("t1_bottom_rout", 0, 430, 329, pat(430, 329));
        scan_row(330, 400, 400);
        chk_px("t1_bottom_out", 0, 400, 330, pat(400, 330));

        // Mid-frame position change only shows after the next latch
        vblank();
        scan_row(100, 0, 1);
        x0[0] = 12'd200; x1[0] = 12'd600;
        scan_row(300, 399, 401);
        chk_px("t2_old_pos", 0, 400, 300, 12'hF00);
        vblank();
        scan_row(300, 599, 631);
        chk_px("t2_new_left", 0, 600, 300, 12'hF00);
        chk_px("t2_new_right", 0, 629, 300, 12'hF00);
        chk_px("t2_new_out", 0, 630, 300, pat(630, 300));
        chk_px("t2_direct_new", 1, 600, 300, 12'hF00);
        scan_row(300, 400, 400);
        chk_px("t2_old_gone", 0, 400, 300, pat(400, 300));

        // Hit flash on slot1 (mirrored 100,100 -> screen 700,500)
        act = 4'b0011; x0[1] = 12'd100; y0[1] = 12'd100; x1[1] = 12'd700; y1[1] = 12'd500;
        vblank();
        scan_row(500, 700, 700);
        chk_px("t3_prehit", 0, 700, 500, 12'hF00);
        hit = 4'b0010;
        scan_row(500, 701, 702);
        chk_px("t3_hit_frame", 0, 702, 500, 12'hFFF);
        for (int f = 0; f < 8; f++) begin
            vblank();
            scan_row(500, 700, 700);
            chk_px($sformatf("t3_frame%0d", f), 0, 700, 500, (f < 7) ? 12'hFFF : 12'hF00);
        end
        hit = 4'b0010;
        vblank();
        for (int f = 0; f < 9; f++) begin
            if (f > 0) vblank();
            scan_row(500, 700, 700);
            chk_px($sformatf("t3_reload%0d", f), 0, 700, 500, (f < 8) ? 12'hFFF : 12'hF00);
        end

        // Overlap: slot0 flashing wins over slot2
        act = 4'b0101;
        x0[0] = 12'd400; y0[0] = 12'd300; x0[2] = 12'd390; y0[2] = 12'd300;
        x1[0] = 12'd400; y1[0] = 12'd300; x1[2] = 12'd410; y1[2] = 12'd300;
        hit = 4'b0001;
        vblank();
        scan_row(300, 405, 435);
        chk_px("t4_slot0_only", 0, 405, 300, 12'hFFF);
        chk_px("t4_overlap", 0, 415, 300, 12'hFFF);
        chk_px("t4_slot2_only", 0, 435, 300, 12'hF00);
        chk_px("t4_overlap_dir", 1, 415, 300, 12'hFFF);

        // Edge clipping and no wrap
        act = 4'b1000;
        x0[3] = 12'd820; y0[3] = 12'd300; x1[3] = 12'd790; y1[3] = 12'd300;
        vblank();
        scan_row(300, 0, 11);
        scan_row(300, 788, 799);
        chk_px("t5_clip_l0", 0, 0, 300, 12'hF00);
        chk_px("t5_clip_l9", 0, 9, 300, 12'hF00);
        chk_px("t5_clip_l10", 0, 10, 300, pat(10, 300));
        chk_px("t5_clip_r_none", 0, 799, 300, pat(799, 300));
        chk_px("t5_dir_789", 1, 789, 300, pat(789, 300));
        chk_px("t5_dir_790", 1, 790, 300, 12'hF00);
        chk_px("t5_dir_799", 1, 799, 300, 12'hF00);
        chk_px("t5_dir_0", 1, 0, 300, pat(0, 300));
        x0[3] = 12'd900;
        vblank();
        scan_row(300, 0, 2);
        scan_row(300, 797, 799);
        chk_px("t5_off_l", 0, 0, 300, pat(0, 300));
        chk_px("t5_no_alias", 0, 799, 300, pat(799, 300));

        // Mid-frame reset
        x0[3] = 12'd820;
        vblank();
        scan_row(300, 0, 3);
        chk_px("t6_before", 0, 2, 300, 12'hF00);
        rst = 1'b1;
        drive_px(4, 300, 1'b0, 1'b0);
        check("t6_rst_timing", {6'd0, vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk}, 32'd0);
        check("t6_rst_rgb", {20'd0, vo0.rgb}, 32'd0);
        drive_px(5, 300, 1'b0, 1'b0);
        drive_px(6, 300, 1'b0, 1'b0);
        rst = 1'b0;
        scan_row(300, 0, 11);
        chk_px("t6_no_draw", 0, 5, 300, pat(5, 300));
        vblank();
        scan_row(300, 0, 11);
        chk_px("t6_resume", 0, 5, 300, 12'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
